// File: rtl/add2_arbiter.sv
// add2_arbiter
//
// Round-robin arbiter and sequencer in front of one shared 8-bit add/subtract
// datapath. It accepts one operation at a time from NUM_REQ requesters. It
// launches the datapath with a one-cycle start pulse, then waits for done or a
// timeout. The 9-bit result goes back to the requester that owns the operation.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester request handshake (ready is one-hot)
//   req_op, req_a, req_b  : per-requester opcode (0 add, 1 sub) and packed operands
//   dp_start              : one-cycle launch pulse to the shared datapath
//   dp_op, dp_a, dp_b     : registered operation of the current owner
//   dp_done, dp_result    : datapath completion strobe and 9-bit result
//   rsp_valid/rsp_ready   : per-requester response handshake (valid is one-hot)
//   rsp_data, rsp_err     : returned result, timeout flag
//   busy, grant_id        : not-idle indicator, index of the current owner

module add2_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_op,
    input  logic [8*NUM_REQ-1:0]       req_a,
    input  logic [8*NUM_REQ-1:0]       req_b,
    output logic                       dp_start,
    output logic                       dp_op,
    output logic [7:0]                 dp_a,
    output logic [7:0]                 dp_b,
    input  logic                       dp_done,
    input  logic [8:0]                 dp_result,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [8:0]                 rsp_data,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int PW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Last wait-counter value before the operation is declared timed out.
    localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ptr_q,   ptr_d;
    logic [PW-1:0] gid_q,   gid_d;
    logic          op_q,    op_d;
    logic [7:0]    a_q,     a_d;
    logic [7:0]    b_q,     b_d;
    logic [7:0]    cnt_q,   cnt_d;
    logic [8:0]    rdata_q, rdata_d;
    logic          rerr_q,  rerr_d;

    logic          win_found;
    logic [PW-1:0] win_idx;
    logic          op_sel;
    logic [7:0]    a_sel;
    logic [7:0]    b_sel;

    // (base + off) mod NUM_REQ, with off < NUM_REQ.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return PW'(s);
    endfunction

    // Round-robin search starting at ptr_q; the first valid requester wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!win_found && req_valid[wrap_idx(ptr_q, off)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(ptr_q, off);
            end
        end
    end

    // Operand mux for the winner.
    always_comb begin
        op_sel = 1'b0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PW'(i)) begin
                op_sel = req_op[i];
                a_sel  = req_a[8*i +: 8];
                b_sel  = req_b[8*i +: 8];
            end
        end
    end

    // One-hot handshake outputs.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state_q == S_IDLE) && win_found && (win_idx == PW'(i));
            rsp_valid[i] = (state_q == S_RESP) && (gid_q == PW'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gid_d   = win_idx;
                    op_d    = op_sel;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q + 8'd1;
                // A done in the timeout cycle still counts as a good result.
                if (dp_done) begin
                    rdata_d = dp_result;
                    rerr_d  = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = 9'h1FF;
                    rerr_d  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // The pointer only moves once the owner has taken its result.
                if (rsp_ready[gid_q]) begin
                    state_d = S_IDLE;
                    ptr_d   = (gid_q == LAST_IDX) ? '0 : gid_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    // The counter is zero only in the first EXEC cycle, which gives the pulse.
    assign dp_start = (state_q == S_EXEC) && (cnt_q == 8'd0);
    assign dp_op    = op_q;
    assign dp_a     = a_q;
    assign dp_b     = b_q;
    assign rsp_data = rdata_q;
    assign rsp_err  = rerr_q;
    assign busy     = (state_q != S_IDLE);
    assign grant_id = gid_q;

endmodule

// File: doc/add2_arbiter.md
# add2_arbiter

Round-robin arbiter and sequencer that shares one 8-bit add/subtract datapath among `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake and drives the shared datapath with a start pulse. It then waits for the datapath's done strobe, or times out, and returns the 9-bit result to the owning requester over a second valid/ready handshake. It sits between the requester logic and the single shared add/sub unit.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters. Legal range 2..8.
- `TIMEOUT_CYC`, default 15: maximum number of EXEC cycles spent waiting for `dp_done`. Legal range 1..255.

Ports:
- `clk`, in, 1: sole clock. All logic is on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, `NUM_REQ`: requester i has an operation pending.
- `req_ready`, out, `NUM_REQ`: one-hot accept. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_op`, in, `NUM_REQ`: per-requester opcode. 0 = add, 1 = subtract (a − b).
- `req_a`, in, `8*NUM_REQ`: operand A, packed. Requester i occupies `[8i+7:8i]`.
- `req_b`, in, `8*NUM_REQ`: operand B, packed the same way.
- `dp_start`, out, 1: single-cycle pulse to the shared datapath.
- `dp_op`, out, 1: registered opcode of the owner.
- `dp_a`, out, 8: registered operand A of the owner.
- `dp_b`, out, 8: registered operand B of the owner.
- `dp_done`, in, 1: datapath result is valid this cycle.
- `dp_result`, in, 9: datapath result. Sampled only when `dp_done` = 1.
- `rsp_valid`, out, `NUM_REQ`: one-hot response valid to the owner.
- `rsp_ready`, in, `NUM_REQ`: response accept from each requester.
- `rsp_data`, out, 9: result returned to the owner.
- `rsp_err`, out, 1: 1 means the operation timed out.
- `busy`, out, 1: 1 in any state other than IDLE.
- `grant_id`, out, `$clog2(NUM_REQ)`: index of the current owner.

## Operation

- The FSM has three states: IDLE, EXEC, RESP.
- Round-robin pointer `ptr`:
  - The winner is the first i with `req_valid[i]`, searching `ptr`, `ptr+1`, … with wrap-around modulo `NUM_REQ`.
  - `ptr` becomes `(grant_id+1) mod NUM_REQ` only when a response handshake completes. It is not updated at accept.
- IDLE:
  - If any `req_valid` is set, `req_ready[winner]` = 1 combinationally in that same cycle.
  - The owner's `req_op`, `req_a`, `req_b` and the winner index are registered, and the next state is EXEC.
  - `req_ready` is all zeros in every other state.
  - `dp_done` is ignored in IDLE.
- EXEC:
  - `dp_start` = 1 only in the first EXEC cycle.
  - `dp_op`, `dp_a`, `dp_b` hold steady for the whole of EXEC and RESP.
  - A wait counter starts at 0 in the first EXEC cycle and increments each EXEC cycle.
  - `dp_done` is honoured in any EXEC cycle, including the `dp_start` cycle. On it, `dp_result` is captured into `rsp_data`, `rsp_err` = 0, and the next state is RESP.
  - If the counter reaches `TIMEOUT_CYC` − 1 without `dp_done`: `rsp_data` = 9'h1FF, `rsp_err` = 1, and the next state is RESP.
  - If `dp_done` and timeout occur in the same cycle, `dp_done` wins.
- RESP:
  - `rsp_valid[grant_id]` = 1 and is held until `rsp_ready[grant_id]` = 1.
  - On that handshake the next state is IDLE and `ptr` advances.
  - `rsp_ready` bits of non-owners are ignored.
  - `dp_done` is ignored in RESP.
- `req_valid` changes of non-owners have no effect outside IDLE.
- Arithmetic is the datapath's job; the block passes 9-bit results through untouched.
- Reset (synchronous, any state), evaluated at the next rising edge:
  - State returns to IDLE and `ptr` = 0.
  - All of `req_ready`, `dp_start`, `dp_op`, `dp_a`, `dp_b`, `rsp_valid`, `rsp_data`, `rsp_err`, `busy`, `grant_id` are 0.
  - An in-flight operation is abandoned with no response.
  - A `dp_done` arriving after reset is ignored.

## Timing

- Accept happens in cycle T (IDLE). `dp_start` pulses in cycle T+1.
- If `dp_done` arrives in cycle T+k (k ≥ 1), `rsp_valid` rises in cycle T+k+1.
- With `rsp_ready` already high, the FSM returns to IDLE at T+k+2, and the next accept can occur in that cycle.
- Minimum period per operation is 3 cycles, reached when `dp_done` coincides with `dp_start`.
- Timeout: `rsp_valid` rises `TIMEOUT_CYC` + 1 cycles after accept.
- `busy` = 1 from T+1 through the RESP handshake cycle inclusive.
- `grant_id` is registered and valid from T+1 to the end of RESP.

## Test plan

- Reset, then requester 1 only: op=0, a=8'd200, b=8'd100. Required: accept in the first cycle, `dp_start` one cycle later with `dp_a`=200, `dp_b`=100. Return `dp_done` with 9'd300 two cycles after `dp_start` → `rsp_valid`=4'b0010, `rsp_data`=9'd300, `rsp_err`=0.
- All four requesters valid continuously; datapath returns done one cycle after start; `rsp_ready` tied high. Required: grant order 0,1,2,3,0, with `rsp_valid` edges every 4 cycles.
- Subtract a=8'd5, b=8'd10; datapath returns 9'h1FB. Required: `rsp_data`=9'h1FB passed through unchanged.
- Datapath never asserts done, `TIMEOUT_CYC`=15. Required: `rsp_valid` rises 16 cycles after accept, `rsp_data`=9'h1FF, `rsp_err`=1.
- `dp_done` in the same cycle as `dp_start`. Required: RESP the next cycle. Hold `rsp_ready`=0 for 5 cycles → `rsp_valid` held for 5 cycles and no new accept during that time.
- Assert `rst` for one cycle mid-EXEC, then pulse `dp_done`. Required: all outputs 0 the cycle after reset, no response issued, and the next grant goes to requester 0.
